// File: rtl/bar_uart_report_if.sv
// bar_uart_report_if: signal bundle between the scan stage / board pin and bar_uart_report.
//   loc_y     : current raster line (driven by the video timing side)
//   scan_data : 13 BCD digits from the scanner, digit 0 leading, digit 12 check digit
//   uart_tx   : serial line, idle high
//   tx_busy   : report engine active (not idle)
//   check_ok  : result of the last completed check-digit verification
//   code_out  : last captured digits
// master = producer of loc_y/scan_data, slave = bar_uart_report.
interface bar_uart_report_if;
    logic [9:0]       loc_y;
    logic [12:0][3:0] scan_data;
    logic             uart_tx;
    logic             tx_busy;
    logic             check_ok;
    logic [12:0][3:0] code_out;

    modport master (
        output loc_y, scan_data,
        input  uart_tx, tx_busy, check_ok, code_out
    );

    modport slave (
        input  loc_y, scan_data,
        output uart_tx, tx_busy, check_ok, code_out
    );
endinterface

// File: rtl/bar_uart_report.sv
// bar_uart_report: once per frame snapshots the scanner's 13 EAN-13 digits, verifies the
// check digit with a serial accumulate / subtract-ten datapath, suppresses repeats of the
// last reported code and sends the code as a 16-byte ASCII line ("ddddddddddddd" + V/X +
// CR LF) on an 8N1 UART.
// Ports:
//   clk : pixel clock
//   rst : asynchronous active-high reset (line returns high at once)
//   bus : bar_uart_report_if.slave (loc_y, scan_data in; uart_tx, tx_busy, check_ok,
//         code_out out)
module bar_uart_report #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter logic [9:0]  CAP_LINE  = 10'd123,
    parameter bit          DEDUP     = 1'b1
) (
    input logic              clk,
    input logic              rst,
    bar_uart_report_if.slave bus
);

    localparam int unsigned BitCyc = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CntW   = (BitCyc > 1) ? $clog2(BitCyc) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(BitCyc - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StCheck,
        StMod,
        StDecide,
        StTxLoad,
        StTxBit
    } state_t;

    state_t           state;
    logic             line_hit_d;
    logic [12:0][3:0] code_q;
    logic [7:0]       acc;
    logic [3:0]       idx;
    logic             bad;
    logic             check_ok_q;
    logic             busy_q;
    logic             uart_tx_q;
    logic             last_valid;
    logic             last_ok;
    logic [12:0][3:0] last_code;
    logic [3:0]       byte_idx;
    logic [3:0]       bit_idx;
    logic [CntW-1:0]  baud_cnt;
    // Stop bit + data bits still to send; the start bit is driven directly at load time.
    logic [8:0]       shift_q;

    logic             line_hit;
    logic             trigger;
    logic [15:0][3:0] code_pad;
    logic [3:0]       cur_digit;
    logic [7:0]       digit8;
    logic [7:0]       addend;
    logic             snap_bad;
    logic [3:0]       exp_digit;
    logic             check_new;
    logic             dup;
    logic [3:0]       byte_digit;
    logic [7:0]       cur_byte;

    assign line_hit = (bus.loc_y == CAP_LINE);
    assign trigger  = line_hit & ~line_hit_d;

    // Padded to 16 entries so 4-bit indices never leave the array.
    assign code_pad  = {12'h000, code_q};
    assign cur_digit = code_pad[idx];
    assign digit8    = {4'h0, cur_digit};
    assign addend    = idx[0] ? (digit8 + (digit8 << 1)) : digit8;

    always_comb begin
        snap_bad = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (bus.scan_data[i] > 4'd9) snap_bad = 1'b1;
        end
    end

    // acc is already reduced below ten when this is used.
    assign exp_digit = (acc == 8'd0) ? 4'd0 : (4'd10 - acc[3:0]);
    assign check_new = ~bad & (exp_digit == code_q[12]);
    assign dup       = DEDUP && last_valid && (last_code == code_q) && (last_ok == check_new);

    assign byte_digit = code_pad[byte_idx];

    always_comb begin
        cur_byte = 8'h0A;
        if (byte_idx < 4'd13) begin
            cur_byte = (byte_digit > 4'd9) ? 8'h3F : (8'h30 + {4'h0, byte_digit});
        end else if (byte_idx == 4'd13) begin
            cur_byte = check_ok_q ? 8'h56 : 8'h58;
        end else if (byte_idx == 4'd14) begin
            cur_byte = 8'h0D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            line_hit_d <= 1'b0;
            code_q     <= '0;
            acc        <= 8'd0;
            idx        <= 4'd0;
            bad        <= 1'b0;
            check_ok_q <= 1'b0;
            busy_q     <= 1'b0;
            uart_tx_q  <= 1'b1;
            last_valid <= 1'b0;
            last_ok    <= 1'b0;
            last_code  <= '0;
            byte_idx   <= 4'd0;
            bit_idx    <= 4'd0;
            baud_cnt   <= '0;
            shift_q    <= 9'h1FF;
        end else begin
            line_hit_d <= line_hit;
            case (state)
                StIdle: begin
                    if (trigger) begin
                        busy_q <= 1'b1;
                        state  <= StSnap;
                    end
                end
                StSnap: begin
                    code_q <= bus.scan_data;
                    acc    <= 8'd0;
                    idx    <= 4'd0;
                    bad    <= snap_bad;
                    state  <= StCheck;
                end
                StCheck: begin
                    acc <= acc + addend;
                    idx <= idx + 4'd1;
                    if (idx == 4'd11) state <= StMod;
                end
                StMod: begin
                    // One subtraction per cycle; exit once the remainder is below ten.
                    if (acc >= 8'd10) acc <= acc - 8'd10;
                    else state <= StDecide;
                end
                StDecide: begin
                    check_ok_q <= check_new;
                    if (dup) begin
                        busy_q <= 1'b0;
                        state  <= StIdle;
                    end else begin
                        last_valid <= 1'b1;
                        last_code  <= code_q;
                        last_ok    <= check_new;
                        byte_idx   <= 4'd0;
                        state      <= StTxLoad;
                    end
                end
                StTxLoad: begin
                    shift_q   <= {1'b1, cur_byte};
                    bit_idx   <= 4'd0;
                    baud_cnt  <= '0;
                    uart_tx_q <= 1'b0;
                    state     <= StTxBit;
                end
                StTxBit: begin
                    if (baud_cnt == BaudLast) begin
                        baud_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            // Line stays high (stop level) through the next load cycle.
                            if (byte_idx == 4'd15) begin
                                busy_q <= 1'b0;
                                state  <= StIdle;
                            end else begin
                                byte_idx <= byte_idx + 4'd1;
                                state    <= StTxLoad;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 4'd1;
                            uart_tx_q <= shift_q[0];
                            shift_q   <= {1'b1, shift_q[8:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.uart_tx  = uart_tx_q;
    assign bus.tx_busy  = busy_q;
    assign bus.check_ok = check_ok_q;
    assign bus.code_out = code_q;

endmodule
